// File: rtl/enc_tx_sched.sv
// enc_tx_sched: transmit symbol scheduler feeding the 8b/10b encoder inputs
// (A..H on ENC_D[0..7], K on ENC_K). After reset or link re-enable it sends a
// run of K28.5 commas, then streams user bytes over valid/ready and fills
// idle slots with commas.
// Optional feature macro: ENC_TX_SCHED_PERIODIC_ALIGN_EN
//   defined   -> a comma is forced (SKIP state) after ALIGN_PERIOD
//                consecutive non-comma symbols.
//   undefined -> no period counter and no SKIP state.
module enc_tx_sched #(
  parameter int         ALIGN_CNT    = 16,
  parameter int         ALIGN_PERIOD = 256,
  parameter logic [7:0] COMMA        = 8'hBC
) (
  input  logic       SBYTECLK,
  input  logic       RST_N,
  input  logic       EN,
  input  logic [7:0] TX_DATA,
  input  logic       TX_K,
  input  logic       TX_VALID,
  output logic       TX_READY,
  output logic [7:0] ENC_D,
  output logic       ENC_K,
  output logic       ALIGNED
);

  localparam int AW = $clog2(ALIGN_CNT + 1);
  localparam int PW = $clog2(ALIGN_PERIOD + 1);

  localparam logic [AW-1:0] A_ONE      = AW'(32'd1);
  localparam logic [AW-1:0] ALIGN_LAST = AW'(ALIGN_CNT);

  // Reject parameter values the scheduler cannot honour.
  if (ALIGN_CNT < 1) begin : g_bad_align_cnt
    $error("enc_tx_sched: ALIGN_CNT must be >= 1");
  end
  if (ALIGN_PERIOD < 2) begin : g_bad_align_period
    $error("enc_tx_sched: ALIGN_PERIOD must be >= 2");
  end

`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_RUN   = 2'd1,
    ST_SKIP  = 2'd2
  } state_t;

  localparam logic [PW-1:0] P_ONE  = PW'(32'd1);
  localparam logic [PW-1:0] P_LAST = PW'(ALIGN_PERIOD - 1);

  logic [PW-1:0] period_cnt_r;
  logic [PW-1:0] period_cnt_nxt_s;
  logic          user_comma_s;
`else
  typedef enum logic [1:0] {
    ST_ALIGN = 2'd0,
    ST_RUN   = 2'd1
  } state_t;
`endif

  state_t        state_r;
  state_t        state_nxt_s;
  logic [AW-1:0] align_cnt_r;
  logic [AW-1:0] align_cnt_nxt_s;
  logic [AW-1:0] align_inc_s;
  logic [7:0]    enc_d_r;
  logic [7:0]    enc_d_nxt_s;
  logic          enc_k_r;
  logic          enc_k_nxt_s;

  // Next-state, counter and symbol selection; a comma is the default symbol.
  always_comb begin
    state_nxt_s     = state_r;
    align_cnt_nxt_s = align_cnt_r;
    enc_d_nxt_s     = COMMA;
    enc_k_nxt_s     = 1'b1;
    align_inc_s     = align_cnt_r + A_ONE;
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
    period_cnt_nxt_s = period_cnt_r;
    user_comma_s     = TX_K & (TX_DATA == COMMA);
`endif
    case (state_r)
      ST_ALIGN: begin
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
        period_cnt_nxt_s = {PW{1'b0}};
`endif
        if (EN) begin
          if (align_inc_s == ALIGN_LAST) begin
            state_nxt_s     = ST_RUN;
            align_cnt_nxt_s = {AW{1'b0}};
          end else begin
            align_cnt_nxt_s = align_inc_s;
          end
        end else begin
          align_cnt_nxt_s = {AW{1'b0}};
        end
      end
      ST_RUN: begin
        if (!EN) begin
          // Link dropped: the offered byte stays with the user.
          state_nxt_s     = ST_ALIGN;
          align_cnt_nxt_s = {AW{1'b0}};
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
          period_cnt_nxt_s = {PW{1'b0}};
`endif
        end else if (TX_VALID) begin
          enc_d_nxt_s = TX_DATA;
          enc_k_nxt_s = TX_K;
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
          // A user-sent K28.5 counts as a comma and restarts the run.
          if (user_comma_s) begin
            period_cnt_nxt_s = {PW{1'b0}};
          end else begin
            period_cnt_nxt_s = period_cnt_r + P_ONE;
            if (period_cnt_r == P_LAST) begin
              state_nxt_s = ST_SKIP;
            end else begin
              state_nxt_s = ST_RUN;
            end
          end
`endif
        end else begin
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
          period_cnt_nxt_s = {PW{1'b0}};
`endif
          state_nxt_s = ST_RUN;
        end
      end
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
      ST_SKIP: begin
        period_cnt_nxt_s = {PW{1'b0}};
        align_cnt_nxt_s  = {AW{1'b0}};
        if (EN) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_ALIGN;
        end
      end
`endif
      default: begin
        state_nxt_s     = ST_ALIGN;
        align_cnt_nxt_s = {AW{1'b0}};
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
        period_cnt_nxt_s = {PW{1'b0}};
`endif
      end
    endcase
  end

  // State, counters and encoder output registers with synchronous reset.
  always_ff @(posedge SBYTECLK) begin
    if (!RST_N) begin
      state_r     <= ST_ALIGN;
      align_cnt_r <= {AW{1'b0}};
      enc_d_r     <= COMMA;
      enc_k_r     <= 1'b1;
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
      period_cnt_r <= {PW{1'b0}};
`endif
    end else begin
      state_r     <= state_nxt_s;
      align_cnt_r <= align_cnt_nxt_s;
      enc_d_r     <= enc_d_nxt_s;
      enc_k_r     <= enc_k_nxt_s;
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
      period_cnt_r <= period_cnt_nxt_s;
`endif
    end
  end

  // Ready and aligned depend only on state and EN, never on TX_VALID.
  assign TX_READY = (state_r == ST_RUN) & EN;
  assign ALIGNED  = (state_r != ST_ALIGN);
  assign ENC_D    = enc_d_r;
  assign ENC_K    = enc_k_r;

endmodule

// File: tb/tb_enc_tx_sched.sv
// Directed self-checking bench for enc_tx_sched (ALIGN_CNT=4, ALIGN_PERIOD=4).
// Expected streams follow ENC_TX_SCHED_PERIODIC_ALIGN_EN when it is defined.
module tb_enc_tx_sched;

  logic       SBYTECLK = 1'b0;
  logic       RST_N    = 1'b0;
  logic       EN       = 1'b1;
  logic [7:0] TX_DATA  = 8'h00;
  logic       TX_K     = 1'b0;
  logic       TX_VALID = 1'b0;
  logic       TX_READY;
  logic [7:0] ENC_D;
  logic       ENC_K;
  logic       ALIGNED;

  int total_cnt = 0;
  int bad_cnt   = 0;

  logic [8:0] tx_q[$];
  logic [9:0] exp_q[$];

  enc_tx_sched #(
    .ALIGN_CNT   (4),
    .ALIGN_PERIOD(4),
    .COMMA       (8'hBC)
  ) dut (
    .SBYTECLK(SBYTECLK),
    .RST_N   (RST_N),
    .EN      (EN),
    .TX_DATA (TX_DATA),
    .TX_K    (TX_K),
    .TX_VALID(TX_VALID),
    .TX_READY(TX_READY),
    .ENC_D   (ENC_D),
    .ENC_K   (ENC_K),
    .ALIGNED (ALIGNED)
  );

  // Free-running byte clock.
  always #5 SBYTECLK = ~SBYTECLK;

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total_cnt++;
    if (got !== exp) begin
      bad_cnt++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge SBYTECLK);
    #1;
  endtask

  // Pack {ready, k, data} for comparison.
  function automatic logic [9:0] ev(input logic rdy, input logic k, input logic [7:0] d);
    return {rdy, k, d};
  endfunction

  task automatic check_out(input string tag, input logic [9:0] exp, input logic aln);
    check_value({tag, "_out"}, {22'd0, TX_READY, ENC_K, ENC_D}, {22'd0, exp});
    check_value({tag, "_aln"}, {31'd0, ALIGNED}, {31'd0, aln});
  endtask

  // Offer tx_q bytes with valid/ready for exp_q.size() cycles, checking each slot.
  task automatic run_stream(input string tag);
    logic acc;
    for (int i = 0; i < exp_q.size(); i++) begin
      if (tx_q.size() > 0) begin
        TX_VALID = 1'b1;
        {TX_K, TX_DATA} = tx_q[0];
      end else begin
        TX_VALID = 1'b0;
      end
      acc = TX_VALID & TX_READY;
      tick();
      if (acc) void'(tx_q.pop_front());
      check_value($sformatf("%s[%0d]", tag, i), {22'd0, TX_READY, ENC_K, ENC_D}, {22'd0, exp_q[i]});
    end
    TX_VALID = 1'b0;
    check_value({tag, "_left"}, tx_q.size(), 32'd0);
    tx_q.delete();
    exp_q.delete();
  endtask

  task automatic realign(input string tag);
    for (int i = 1; i <= 3; i++) begin
      tick();
      check_out($sformatf("%s_al%0d", tag, i), ev(1'b0, 1'b1, 8'hBC), 1'b0);
    end
    tick();
    check_out({tag, "_al4"}, ev(1'b1, 1'b1, 8'hBC), 1'b1);
  endtask

  initial begin
    // Reset with EN high.
    tick();
    tick();
    check_out("rst", ev(1'b0, 1'b1, 8'hBC), 1'b0);
    RST_N = 1'b1;
    realign("init");

    // Streaming with a gap.
    tx_q = '{9'h001, 9'h002, 9'h003};
    exp_q = '{ev(1'b1, 1'b0, 8'h01), ev(1'b1, 1'b0, 8'h02), ev(1'b1, 1'b0, 8'h03), ev(1'b1, 1'b1, 8'hBC)};
    run_stream("str_a");
    tx_q = '{9'h004};
    exp_q = '{ev(1'b1, 1'b0, 8'h04), ev(1'b1, 1'b1, 8'hBC)};
    run_stream("str_b");

    // Continuous data 10..17.
    tx_q = '{9'h010, 9'h011, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016, 9'h017};
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
    exp_q = '{ev(1'b1, 1'b0, 8'h10), ev(1'b1, 1'b0, 8'h11), ev(1'b1, 1'b0, 8'h12), ev(1'b0, 1'b0, 8'h13),
              ev(1'b1, 1'b1, 8'hBC), ev(1'b1, 1'b0, 8'h14), ev(1'b1, 1'b0, 8'h15), ev(1'b1, 1'b0, 8'h16),
              ev(1'b0, 1'b0, 8'h17), ev(1'b1, 1'b1, 8'hBC)};
`else
    exp_q = '{ev(1'b1, 1'b0, 8'h10), ev(1'b1, 1'b0, 8'h11), ev(1'b1, 1'b0, 8'h12), ev(1'b1, 1'b0, 8'h13),
              ev(1'b1, 1'b0, 8'h14), ev(1'b1, 1'b0, 8'h15), ev(1'b1, 1'b0, 8'h16), ev(1'b1, 1'b0, 8'h17),
              ev(1'b1, 1'b1, 8'hBC)};
`endif
    run_stream("cont");

    // User K28.5 restarts the non-comma run.
    tx_q = '{9'h010, 9'h011, 9'h1BC, 9'h012, 9'h013, 9'h014, 9'h015, 9'h016};
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
    exp_q = '{ev(1'b1, 1'b0, 8'h10), ev(1'b1, 1'b0, 8'h11), ev(1'b1, 1'b1, 8'hBC), ev(1'b1, 1'b0, 8'h12),
              ev(1'b1, 1'b0, 8'h13), ev(1'b1, 1'b0, 8'h14), ev(1'b0, 1'b0, 8'h15), ev(1'b1, 1'b1, 8'hBC),
              ev(1'b1, 1'b0, 8'h16), ev(1'b1, 1'b1, 8'hBC)};
`else
    exp_q = '{ev(1'b1, 1'b0, 8'h10), ev(1'b1, 1'b0, 8'h11), ev(1'b1, 1'b1, 8'hBC), ev(1'b1, 1'b0, 8'h12),
              ev(1'b1, 1'b0, 8'h13), ev(1'b1, 1'b0, 8'h14), ev(1'b1, 1'b0, 8'h15), ev(1'b1, 1'b0, 8'h16),
              ev(1'b1, 1'b1, 8'hBC)};
`endif
    run_stream("ucomma");

    // EN dropped for two cycles while byte 22 is offered.
    TX_VALID = 1'b1;
    {TX_K, TX_DATA} = 9'h020;
    tick();
    check_out("en_20", ev(1'b1, 1'b0, 8'h20), 1'b1);
    {TX_K, TX_DATA} = 9'h021;
    tick();
    check_out("en_21", ev(1'b1, 1'b0, 8'h21), 1'b1);
    {TX_K, TX_DATA} = 9'h022;
    EN = 1'b0;
    #1;
    check_value("en_rdy_drop", {31'd0, TX_READY}, 32'd0);
    tick();
    check_out("en_low1", ev(1'b0, 1'b1, 8'hBC), 1'b0);
    tick();
    check_out("en_low2", ev(1'b0, 1'b1, 8'hBC), 1'b0);
    EN = 1'b1;
    realign("reen");
    tick();
    check_out("en_22", ev(1'b1, 1'b0, 8'h22), 1'b1);
    {TX_K, TX_DATA} = 9'h023;
    tick();
    check_out("en_23", ev(1'b1, 1'b0, 8'h23), 1'b1);
    TX_VALID = 1'b0;
    tick();
    check_out("en_idle", ev(1'b1, 1'b1, 8'hBC), 1'b1);

    // Reset while in SKIP (macro build) with a byte pending.
    tx_q = '{9'h030, 9'h031, 9'h032, 9'h033};
`ifdef ENC_TX_SCHED_PERIODIC_ALIGN_EN
    exp_q = '{ev(1'b1, 1'b0, 8'h30), ev(1'b1, 1'b0, 8'h31), ev(1'b1, 1'b0, 8'h32), ev(1'b0, 1'b0, 8'h33)};
`else
    exp_q = '{ev(1'b1, 1'b0, 8'h30), ev(1'b1, 1'b0, 8'h31), ev(1'b1, 1'b0, 8'h32), ev(1'b1, 1'b0, 8'h33)};
`endif
    run_stream("pre_rst");
    TX_VALID = 1'b1;
    {TX_K, TX_DATA} = 9'h034;
    RST_N = 1'b0;
    tick();
    check_out("skip_rst", ev(1'b0, 1'b1, 8'hBC), 1'b0);
    RST_N = 1'b1;
    realign("post_rst");
    tick();
    check_out("rst_34", ev(1'b1, 1'b0, 8'h34), 1'b1);
    TX_VALID = 1'b0;
    tick();
    check_out("rst_idle", ev(1'b1, 1'b1, 8'hBC), 1'b1);

    $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
    $finish;
  end

endmodule
